// File: rtl/branch_pred_unit.sv
// Branch resolution and 2-bit saturating direction predictor for a MIPS-style pipeline.
// Prediction is combinational at fetch; resolution and table training happen at execute.
module branch_pred_unit #(
  parameter int BHT_DEPTH = 64,
  parameter int IDX_W     = 6,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      if_pc,
  output logic             pred_taken,
  input  logic             ex_valid,
  input  logic             ex_stall,
  input  logic             flush,
  input  logic [5:0]       ex_op,
  input  logic [4:0]       ex_rt,
  input  logic [31:0]      ex_pc,
  input  logic [31:0]      ex_rs_val,
  input  logic [31:0]      ex_rt_val,
  input  logic             ex_pred,
  output logic             res_valid,
  output logic             res_taken,
  output logic             res_mispredict,
  output logic             res_link,
  output logic [31:0]      res_pc,
  output logic [CNT_W-1:0] mispred_cnt
);

  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_BNE    = 6'b000101;
  localparam logic [5:0] OP_BLEZ   = 6'b000110;
  localparam logic [5:0] OP_BGTZ   = 6'b000111;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_t;

  ctr_t bht [BHT_DEPTH];

  logic [IDX_W-1:0] if_idx;
  logic [IDX_W-1:0] ex_idx;
  logic             is_branch;
  logic             br_taken;
  logic             br_link;
  logic             rs_neg;
  logic             rs_zero;
  logic             accept;
  logic             mispredict;
  ctr_t             ctr_cur;
  ctr_t             ctr_next;

  logic             valid_q;
  logic             taken_q;
  logic             mispredict_q;
  logic             link_q;

  logic             unused_pc_bits;

  assign if_idx = if_pc[IDX_W+1:2];
  assign ex_idx = ex_pc[IDX_W+1:2];
  assign unused_pc_bits = ^{if_pc[31:IDX_W+2], if_pc[1:0]};

  // No bypass from the execute-stage update: a same-index fetch sees the old counter.
  assign pred_taken = (bht[if_idx] == WT) || (bht[if_idx] == ST);

  assign rs_neg  = ex_rs_val[31];
  assign rs_zero = (ex_rs_val == 32'd0);

  always_comb begin
    is_branch = 1'b0;
    br_taken  = 1'b0;
    br_link   = 1'b0;
    case (ex_op)
      OP_BEQ: begin
        is_branch = 1'b1;
        br_taken  = (ex_rs_val == ex_rt_val);
      end
      OP_BNE: begin
        is_branch = 1'b1;
        br_taken  = (ex_rs_val != ex_rt_val);
      end
      OP_BLEZ: begin
        is_branch = 1'b1;
        br_taken  = rs_neg | rs_zero;
      end
      OP_BGTZ: begin
        is_branch = 1'b1;
        br_taken  = ~rs_neg & ~rs_zero;
      end
      OP_REGIMM: begin
        // Link variants differ only in rt[4]; linking happens whether or not the branch is taken.
        case (ex_rt)
          5'b00000, 5'b10000: begin
            is_branch = 1'b1;
            br_taken  = rs_neg;
            br_link   = ex_rt[4];
          end
          5'b00001, 5'b10001: begin
            is_branch = 1'b1;
            br_taken  = ~rs_neg;
            br_link   = ex_rt[4];
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  assign accept     = ex_valid & ~ex_stall & ~flush & is_branch;
  assign mispredict = br_taken ^ ex_pred;

  always_comb begin
    ctr_cur  = bht[ex_idx];
    ctr_next = ctr_cur;
    case (ctr_cur)
      SNT: ctr_next = br_taken ? WNT : SNT;
      WNT: ctr_next = br_taken ? WT  : SNT;
      WT:  ctr_next = br_taken ? ST  : WNT;
      ST:  ctr_next = br_taken ? ST  : WT;
      default: ctr_next = WNT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BHT_DEPTH; i++) begin
        bht[i] <= WNT;
      end
    end else if (accept) begin
      bht[ex_idx] <= ctr_next;
    end
  end

  // Flush wins over stall; a stall without flush freezes the result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q      <= 1'b0;
      taken_q      <= 1'b0;
      mispredict_q <= 1'b0;
      link_q       <= 1'b0;
      res_pc       <= 32'd0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (!ex_stall) begin
      valid_q <= accept;
      if (accept) begin
        taken_q      <= br_taken;
        mispredict_q <= mispredict;
        link_q       <= br_link;
        res_pc       <= ex_pc;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mispred_cnt <= '0;
    end else if (accept && mispredict && (mispred_cnt != '1)) begin
      mispred_cnt <= mispred_cnt + CNT_W'(1);
    end
  end

  assign res_valid      = valid_q;
  assign res_taken      = valid_q & taken_q;
  assign res_mispredict = valid_q & mispredict_q;
  assign res_link       = valid_q & link_q;

endmodule

// File: tb/tb_branch_pred_unit.sv
// Self-checking bench for branch_pred_unit: vector table plus hand sequences, scoreboard queue
// of expected results; a CNT_W=4 copy runs alongside to observe counter saturation.
module tb_branch_pred_unit;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_REGIMM  = 6'b000001;
  localparam logic [5:0] OP_J       = 6'b000010;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] OP_BNE     = 6'b000101;
  localparam logic [5:0] OP_BLEZ    = 6'b000110;
  localparam logic [5:0] OP_BGTZ    = 6'b000111;

  typedef struct {
    logic [5:0]  op;
    logic [4:0]  rt;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] pc;
    logic        pred;
    logic        valid;
    logic        stall;
    logic        flush;
    logic        exp_valid;
    logic        exp_taken;
    logic        exp_mis;
    logic        exp_link;
  } vec_t;

  typedef struct {
    logic        valid;
    logic        taken;
    logic        mis;
    logic        link;
    logic [31:0] pc;
    logic [15:0] cnt;
    logic [3:0]  cnt4;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic        ex_valid;
  logic        ex_stall;
  logic        flush;
  logic [5:0]  ex_op;
  logic [4:0]  ex_rt;
  logic [31:0] ex_pc;
  logic [31:0] ex_rs_val;
  logic [31:0] ex_rt_val;
  logic        ex_pred;
  logic        res_valid;
  logic        res_taken;
  logic        res_mispredict;
  logic        res_link;
  logic [31:0] res_pc;
  logic [15:0] mispred_cnt;

  logic        pred_taken4;
  logic        res_valid4;
  logic        res_taken4;
  logic        res_mispredict4;
  logic        res_link4;
  logic [31:0] res_pc4;
  logic [3:0]  mispred_cnt4;

  int tests_run = 0;
  int tests_failed = 0;

  exp_t        sb_q[$];
  exp_t        last_exp;
  logic [15:0] m_cnt;
  logic [3:0]  m_cnt4;
  vec_t        vecs[20];

  branch_pred_unit #(.BHT_DEPTH(64), .IDX_W(6), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .if_pc(if_pc), .pred_taken(pred_taken),
    .ex_valid(ex_valid), .ex_stall(ex_stall), .flush(flush), .ex_op(ex_op), .ex_rt(ex_rt),
    .ex_pc(ex_pc), .ex_rs_val(ex_rs_val), .ex_rt_val(ex_rt_val), .ex_pred(ex_pred),
    .res_valid(res_valid), .res_taken(res_taken), .res_mispredict(res_mispredict),
    .res_link(res_link), .res_pc(res_pc), .mispred_cnt(mispred_cnt)
  );

  branch_pred_unit #(.BHT_DEPTH(64), .IDX_W(6), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .if_pc(if_pc), .pred_taken(pred_taken4),
    .ex_valid(ex_valid), .ex_stall(ex_stall), .flush(flush), .ex_op(ex_op), .ex_rt(ex_rt),
    .ex_pc(ex_pc), .ex_rs_val(ex_rs_val), .ex_rt_val(ex_rt_val), .ex_pred(ex_pred),
    .res_valid(res_valid4), .res_taken(res_taken4), .res_mispredict(res_mispredict4),
    .res_link(res_link4), .res_pc(res_pc4), .mispred_cnt(mispred_cnt4)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mk(logic [5:0] op, logic [4:0] rt, logic [31:0] rs_val,
                              logic [31:0] rt_val, logic [31:0] pc, logic pred, logic valid,
                              logic stall, logic flush_in, logic ev, logic et, logic em,
                              logic el);
    vec_t v;
    v.op = op; v.rt = rt; v.rs_val = rs_val; v.rt_val = rt_val; v.pc = pc;
    v.pred = pred; v.valid = valid; v.stall = stall; v.flush = flush_in;
    v.exp_valid = ev; v.exp_taken = et; v.exp_mis = em; v.exp_link = el;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic reset_model();
    last_exp = '{default: '0};
    m_cnt    = 16'd0;
    m_cnt4   = 4'd0;
    sb_q.delete();
  endtask

  task automatic drive_idle();
    ex_valid = 1'b0; ex_stall = 1'b0; flush = 1'b0;
    ex_op = OP_SPECIAL; ex_rt = 5'd0; ex_pc = 32'd0;
    ex_rs_val = 32'd0; ex_rt_val = 32'd0; ex_pred = 1'b0;
  endtask

  task automatic checkOutput();
    exp_t e;
    if (sb_q.size() == 0) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL scoreboard_empty: got 0 entries expected 1");
      return;
    end
    e = sb_q.pop_front();
    check("res_valid",      32'(res_valid),      32'(e.valid));
    check("res_taken",      32'(res_taken),      32'(e.taken));
    check("res_mispredict", 32'(res_mispredict), 32'(e.mis));
    check("res_link",       32'(res_link),       32'(e.link));
    check("mispred_cnt",    32'(mispred_cnt),    32'(e.cnt));
    check("mispred_cnt4",   32'(mispred_cnt4),   32'(e.cnt4));
    if (e.valid) check("res_pc", res_pc, e.pc);
  endtask

  // Drives one execute-stage instruction for one cycle and checks the registered result.
  task automatic applyStimulus(input vec_t v, input bit pre_en, input logic pre_exp);
    exp_t e;
    @(negedge clk);
    ex_op = v.op; ex_rt = v.rt; ex_rs_val = v.rs_val; ex_rt_val = v.rt_val;
    ex_pc = v.pc; ex_pred = v.pred; ex_valid = v.valid; ex_stall = v.stall; flush = v.flush;
    if (v.flush) begin
      e = '{default: '0};
      e.cnt = m_cnt;
      e.cnt4 = m_cnt4;
    end else if (v.stall) begin
      e = last_exp;
    end else begin
      e.valid = v.exp_valid; e.taken = v.exp_taken; e.mis = v.exp_mis; e.link = v.exp_link;
      e.pc = v.pc;
      if (v.exp_valid && v.exp_mis) begin
        if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        if (m_cnt4 != 4'hF) m_cnt4 = m_cnt4 + 4'd1;
      end
      e.cnt = m_cnt;
      e.cnt4 = m_cnt4;
    end
    last_exp = e;
    sb_q.push_back(e);
    if (pre_en) begin
      #1;
      check("pred_no_bypass", 32'(pred_taken), 32'(pre_exp));
    end
    @(posedge clk);
    #1;
    checkOutput();
    drive_idle();
  endtask

  task automatic check_pred(input string name, input logic [31:0] pc, input logic exp);
    if_pc = pc;
    #1;
    check(name, 32'(pred_taken), 32'(exp));
  endtask

  initial begin
    drive_idle();
    if_pc = 32'd0;
    rst = 1'b1;
    reset_model();

    vecs[0]  = mk(OP_BEQ,    5'd0,  32'd5,        32'd5, 32'h200, 0, 1, 0, 0, 1, 1, 1, 0);
    vecs[1]  = mk(OP_BEQ,    5'd0,  32'd5,        32'd6, 32'h104, 0, 1, 0, 0, 1, 0, 0, 0);
    vecs[2]  = mk(OP_BNE,    5'd0,  32'd5,        32'd6, 32'h108, 1, 1, 0, 0, 1, 1, 0, 0);
    vecs[3]  = mk(OP_BNE,    5'd0,  32'd7,        32'd7, 32'h10C, 1, 1, 0, 0, 1, 0, 1, 0);
    vecs[4]  = mk(OP_BLEZ,   5'd0,  32'd0,        32'd9, 32'h110, 1, 1, 0, 0, 1, 1, 0, 0);
    vecs[5]  = mk(OP_BLEZ,   5'd0,  32'h80000000, 32'd0, 32'h114, 0, 1, 0, 0, 1, 1, 1, 0);
    vecs[6]  = mk(OP_BLEZ,   5'd0,  32'd1,        32'd0, 32'h118, 0, 1, 0, 0, 1, 0, 0, 0);
    vecs[7]  = mk(OP_BGTZ,   5'd0,  32'd1,        32'd0, 32'h11C, 1, 1, 0, 0, 1, 1, 0, 0);
    vecs[8]  = mk(OP_BGTZ,   5'd0,  32'd0,        32'd0, 32'h120, 1, 1, 0, 0, 1, 0, 1, 0);
    vecs[9]  = mk(OP_BGTZ,   5'd0,  32'hFFFFFFFF, 32'd0, 32'h124, 0, 1, 0, 0, 1, 0, 0, 0);
    vecs[10] = mk(OP_REGIMM, 5'h10, 32'hFFFFFFFF, 32'd0, 32'h128, 1, 1, 0, 0, 1, 1, 0, 1);
    vecs[11] = mk(OP_REGIMM, 5'h00, 32'd0,        32'd0, 32'h12C, 0, 1, 0, 0, 1, 0, 0, 0);
    vecs[12] = mk(OP_REGIMM, 5'h01, 32'd0,        32'd0, 32'h130, 0, 1, 0, 0, 1, 1, 1, 0);
    vecs[13] = mk(OP_REGIMM, 5'h11, 32'h7FFFFFFF, 32'd0, 32'h134, 1, 1, 0, 0, 1, 1, 0, 1);
    vecs[14] = mk(OP_REGIMM, 5'h11, 32'h80000000, 32'd0, 32'h138, 1, 1, 0, 0, 1, 0, 1, 1);
    vecs[15] = mk(OP_REGIMM, 5'h02, 32'hFFFFFFFF, 32'd0, 32'h13C, 0, 1, 0, 0, 0, 0, 0, 0);
    vecs[16] = mk(OP_SPECIAL,5'd0,  32'd1,        32'd1, 32'h140, 0, 1, 0, 0, 0, 0, 0, 0);
    vecs[17] = mk(OP_BEQ,    5'd0,  32'd1,        32'd1, 32'h144, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[18] = mk(OP_BEQ,    5'd0,  32'd1,        32'd1, 32'h148, 0, 1, 0, 1, 0, 0, 0, 0);
    vecs[19] = mk(OP_J,      5'd0,  32'd1,        32'd1, 32'h14C, 0, 1, 0, 0, 0, 0, 0, 0);

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_mispred_cnt", 32'(mispred_cnt), 32'd0);
    check("rst_res_pc", res_pc, 32'd0);
    check_pred("rst_pred_0x0", 32'h0, 1'b0);
    check_pred("rst_pred_0x100", 32'h100, 1'b0);
    check_pred("rst_pred_0xfc", 32'hFC, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // BEQ taken with a not-taken prediction trains the counter to weak-taken
    if_pc = 32'h100;
    applyStimulus(mk(OP_BEQ, 5'd0, 32'd5, 32'd5, 32'h100, 0, 1, 0, 0, 1, 1, 1, 0), 1, 1'b0);
    check_pred("beq_pred_after", 32'h100, 1'b1);

    for (int i = 0; i < 20; i++) applyStimulus(vecs[i], 0, 1'b0);
    check_pred("flushed_pred_0x148", 32'h148, 1'b0);
    check_pred("nonbranch_pred_0x140", 32'h140, 1'b0);

    // Saturation up to strong-taken, then two not-taken back to weak-not-taken
    if_pc = 32'h180;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(mk(OP_BEQ, 5'd0, 32'd3, 32'd3, 32'h180, 1, 1, 0, 0, 1, 1, 0, 0), 0, 1'b0);
      check_pred("sat_up_pred", 32'h180, 1'b1);
    end
    applyStimulus(mk(OP_BEQ, 5'd0, 32'd1, 32'd2, 32'h180, 1, 1, 0, 0, 1, 0, 1, 0), 0, 1'b0);
    check_pred("sat_down1_pred", 32'h180, 1'b1);
    applyStimulus(mk(OP_BEQ, 5'd0, 32'd1, 32'd2, 32'h180, 1, 1, 0, 0, 1, 0, 1, 0), 0, 1'b0);
    check_pred("sat_down2_pred", 32'h180, 1'b0);
    applyStimulus(mk(OP_BEQ, 5'd0, 32'd4, 32'd4, 32'h180, 0, 1, 0, 0, 1, 1, 1, 0), 0, 1'b0);
    check_pred("sat_retrain_pred", 32'h180, 1'b1);

    // Stall holds the previous result and the table; release then accepts the stalled branch
    applyStimulus(mk(OP_BNE, 5'd0, 32'd1, 32'd2, 32'h1C0, 0, 1, 0, 0, 1, 1, 1, 0), 0, 1'b0);
    for (int i = 0; i < 3; i++)
      applyStimulus(mk(OP_REGIMM, 5'h11, 32'd5, 32'd0, 32'h1C4, 1, 1, 1, 0, 1, 1, 0, 1), 0, 1'b0);
    check_pred("stall_table_held", 32'h1C4, 1'b0);
    applyStimulus(mk(OP_REGIMM, 5'h11, 32'd5, 32'd0, 32'h1C4, 1, 1, 0, 0, 1, 1, 0, 1), 0, 1'b0);
    check_pred("unstall_pred", 32'h1C4, 1'b1);
    applyStimulus(mk(OP_BEQ, 5'd0, 32'd1, 32'd1, 32'h1C8, 0, 1, 0, 1, 0, 0, 0, 0), 0, 1'b0);
    check_pred("flush_table_held", 32'h1C8, 1'b0);
    applyStimulus(mk(OP_BEQ, 5'd0, 32'd2, 32'd2, 32'h1CC, 1, 1, 0, 0, 1, 1, 0, 0), 0, 1'b0);
    applyStimulus(mk(OP_BEQ, 5'd0, 32'd2, 32'd3, 32'h1D0, 1, 1, 1, 1, 0, 0, 0, 0), 0, 1'b0);

    // Reset mid-stream with a valid result pending
    applyStimulus(mk(OP_BEQ, 5'd0, 32'd9, 32'd9, 32'h1D4, 0, 1, 0, 0, 1, 1, 1, 0), 0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_res_valid", 32'(res_valid), 32'd0);
    check("midrst_res_taken", 32'(res_taken), 32'd0);
    check("midrst_res_mispredict", 32'(res_mispredict), 32'd0);
    check("midrst_mispred_cnt", 32'(mispred_cnt), 32'd0);
    check("midrst_mispred_cnt4", 32'(mispred_cnt4), 32'd0);
    check("midrst_res_pc", res_pc, 32'd0);
    check_pred("midrst_pred_0x100", 32'h100, 1'b0);
    check_pred("midrst_pred_0x180", 32'h180, 1'b0);
    check_pred("midrst_pred_0x1c4", 32'h1C4, 1'b0);
    reset_model();
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(mk(OP_BEQ, 5'd0, 32'd4, 32'd4, 32'h180, 0, 1, 0, 0, 1, 1, 1, 0), 0, 1'b0);
    check_pred("postrst_weak_nt", 32'h180, 1'b1);

    // Seventeen more mispredicts: the 4-bit counter must stick at 15
    for (int i = 0; i < 17; i++)
      applyStimulus(mk(OP_BEQ, 5'd0, 32'd1, 32'd1, 32'h200, 0, 1, 0, 0, 1, 1, 1, 0), 0, 1'b0);
    check("cnt4_saturated", 32'(mispred_cnt4), 32'd15);
    check("cnt16_total", 32'(mispred_cnt), 32'd18);
    applyStimulus(mk(OP_BEQ, 5'd0, 32'd1, 32'd1, 32'h200, 1, 1, 0, 0, 1, 1, 0, 0), 0, 1'b0);
    check("cnt4_held", 32'(mispred_cnt4), 32'd15);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/branch_pred_unit.md
BRANCH_PRED_UNIT -- requirements
Module: branch_pred_unit

Interface
REQ-001 The block SHALL have parameter BHT_DEPTH, default 64: number of 2-bit branch history counters; a power of two, minimum 4.
REQ-002 The block SHALL have parameter IDX_W, default 6: the table index width, equal to log2(BHT_DEPTH).
REQ-003 The block SHALL have parameter CNT_W, default 16: the width of the mispredict statistics counter.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 The block SHALL have port if_pc, input, 32 bits: fetch-stage PC to predict.
REQ-007 The block SHALL have port pred_taken, output, 1 bit: combinational prediction for if_pc.
REQ-008 The block SHALL have port ex_valid, input, 1 bit: the execute-stage instruction is valid.
REQ-009 The block SHALL have port ex_stall, input, 1 bit: execute stage is stalled, so the block takes no action this cycle.
REQ-010 The block SHALL have port flush, input, 1 bit: discard the result of the current cycle.
REQ-011 The block SHALL have port ex_op, input, 6 bits: instruction opcode.
REQ-012 The block SHALL have port ex_rt, input, 5 bits: rt field, used for REGIMM sub-decode.
REQ-013 The block SHALL have port ex_pc, input, 32 bits: PC of the execute-stage instruction.
REQ-014 The block SHALL have port ex_rs_val, input, 32 bits: rs operand value.
REQ-015 The block SHALL have port ex_rt_val, input, 32 bits: rt operand value.
REQ-016 The block SHALL have port ex_pred, input, 1 bit: the prediction made at fetch for this instruction.
REQ-017 The block SHALL have port res_valid, output, 1 bit: the registered result is valid.
REQ-018 The block SHALL have port res_taken, output, 1 bit: resolved branch direction.
REQ-019 The block SHALL have port res_mispredict, output, 1 bit: resolved direction differs from ex_pred.
REQ-020 The block SHALL have port res_link, output, 1 bit: the instruction is BLTZAL or BGEZAL and writes r31.
REQ-021 The block SHALL have port res_pc, output, 32 bits: ex_pc of the resolved branch.
REQ-022 The block SHALL have port mispred_cnt, output, CNT_W bits: saturating count of mispredictions.

Function
REQ-023 The block SHALL decode branches as follows: BEQ 000100 taken if rs==rt; BNE 000101 taken if rs!=rt; BLEZ 000110 taken if rs<=0 signed; BGTZ 000111 taken if rs>0 signed.
REQ-024 The block SHALL decode REGIMM 000001 by rt: BLTZ 00000 and BLTZAL 10000 taken if rs<0 signed; BGEZ 00001 and BGEZAL 10001 taken if rs>=0 signed; any other rt is not a branch.
REQ-025 The block SHALL treat any other opcode as not a branch.
REQ-026 The block SHALL compute the table index as pc[IDX_W+1:2], for both if_pc and ex_pc.
REQ-027 The block SHALL drive pred_taken as bit 1 of the counter at the if_pc index, combinationally.
REQ-028 The block SHALL define an accepted branch as ex_valid=1 AND ex_stall=0 AND flush=0 AND the decode is a branch.
REQ-029 On an accepted branch, the block SHALL register res_valid=1 and res_taken, res_mispredict, res_link and res_pc on the same edge, giving a latency of 1 cycle.
REQ-030 When no branch is accepted and ex_stall=0, the block SHALL set res_valid=0 on the next edge.
REQ-031 When ex_stall=1 and flush=0, the block SHALL hold all res_* outputs and the table unchanged.
REQ-032 When flush=1, the block SHALL set res_valid=0 on the next edge regardless of ex_stall, with no table or counter update.
REQ-033 When res_valid=0, the block SHALL drive res_taken, res_mispredict and res_link to 0.
REQ-034 The block SHALL implement each counter as a 2-bit saturating state machine: 00 strong-not-taken, 01 weak-not-taken, 10 weak-taken, 11 strong-taken.
REQ-035 On an accepted branch, the block SHALL increment the ex_pc-indexed counter if taken (saturating at 11), otherwise decrement it (saturating at 00).
REQ-036 When the if_pc and ex_pc indices are equal in the update cycle, the block SHALL give pred_taken from the pre-update value, with no bypass.
REQ-037 The block SHALL increment mispred_cnt by 1 on each accepted branch with a mispredict, saturating at all-ones with no wrap.
REQ-038 The block SHALL update only the branch table on the instruction stream, with no effect on non-branch instructions.

Reset
REQ-039 While rst=1, the block SHALL asynchronously set every table counter to 01, res_valid, res_taken, res_mispredict and res_link to 0, res_pc to 0, and mispred_cnt to 0.
REQ-040 A reset asserted mid-operation SHALL discard any pending result, so that res_valid=0 immediately.
REQ-041 After reset, pred_taken SHALL be 0 for every PC.

Verification
REQ-042 Verification SHALL cover: BEQ, rs=5, rt=5, ex_pred=0, pc=0x100 -> next cycle res_valid=1, res_taken=1, res_mispredict=1, mispred_cnt=1; counter[0] goes 01->10 and pred_taken for pc 0x100 becomes 1.
REQ-043 Verification SHALL cover: BLTZAL, rs=0xFFFFFFFF -> res_taken=1, res_link=1; and BLTZ with rs=0 -> res_taken=0, which distinguishes it from BLEZ.
REQ-044 Verification SHALL cover: the same taken branch accepted 4 times -> the counter saturates at 11; then 2 not-taken -> counter 01 and pred_taken=0.
REQ-045 Verification SHALL cover: ex_stall=1 for 3 cycles with a valid branch -> res_* and the table are held; flush=1 together with the branch -> res_valid=0 with no counter change.
REQ-046 Verification SHALL cover: CNT_W=4 with 17 mispredicts -> mispred_cnt=15, held without wrap.
REQ-047 Verification SHALL cover: rst asserted mid-stream after training -> res_valid=0 immediately, all counters 01, mispred_cnt=0.
